// File: rtl/aes_round_sequencer.sv
// AES round sequencer: steps the datapath units through key expansion and the
// round transforms for 128/192/256-bit keys, in either cipher direction, with a per-state watchdog.
module aes_round_sequencer #(
   parameter int MAX_ROUNDS = 14,
   parameter int ROUND_W    = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               key_load,
   input  logic [1:0]         key_size,
   input  logic               data_start,
   input  logic               decrypt,
   input  logic               err_clear,
   input  logic               keyexp_finished,
   input  logic               sbytes_finished,
   input  logic               srows_finished,
   input  logic               mcol_finished,
   input  logic               around_finished,
   output logic               key_capture,
   output logic               data_capture,
   output logic               keyexp_enable,
   output logic               sbytes_enable,
   output logic               srows_enable,
   output logic               mcol_enable,
   output logic               around_enable,
   output logic               inverse,
   output logic [ROUND_W-1:0] roundnum,
   output logic [ROUND_W-1:0] key_index,
   output logic               key_ready,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [3:0]         dbg_state
);

   localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [3:0] {
      S_NOKEY  = 4'd0,
      S_IDLE   = 4'd1,
      S_KEYEXP = 4'd2,
      S_SBYTES = 4'd3,
      S_SROWS  = 4'd4,
      S_MCOL   = 4'd5,
      S_AROUND = 4'd6,
      S_DONE   = 4'd7,
      S_ERROR  = 4'd8
   } state_t;

   state_t             state_q, state_d;
   logic [ROUND_W-1:0] nr_q, nr_d;
   logic [ROUND_W-1:0] r_q, r_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic               inverse_q, inverse_d;
   logic               key_ready_q, key_ready_d;
   logic               key_capture_q, key_capture_d;
   logic               data_capture_q, data_capture_d;

   logic               work_state;
   logic               last_round;
   logic               round_end;
   logic [ROUND_W-1:0] nr_sel;

   assign work_state = (state_q == S_KEYEXP) || (state_q == S_SBYTES) || (state_q == S_SROWS) ||
                       (state_q == S_MCOL)   || (state_q == S_AROUND);
   assign last_round = (r_q == nr_q);

   always_comb begin
      nr_sel = ROUND_W'(10);
      case (key_size)
         2'b00:   nr_sel = ROUND_W'(10);
         2'b01:   nr_sel = ROUND_W'(12);
         2'b10:   nr_sel = ROUND_W'(MAX_ROUNDS);
         default: nr_sel = ROUND_W'(10);
      endcase
   end

   always_comb begin
      state_d        = state_q;
      nr_d           = nr_q;
      r_d            = r_q;
      wd_d           = '0;
      inverse_d      = inverse_q;
      key_ready_d    = key_ready_q;
      key_capture_d  = 1'b0;
      data_capture_d = 1'b0;
      round_end      = 1'b0;

      case (state_q)
         S_NOKEY, S_IDLE: begin
            // key_load outranks data_start when both arrive together
            if (key_load) begin
               if (key_size == 2'b11) begin
                  state_d = S_ERROR;
               end else begin
                  nr_d          = nr_sel;
                  key_capture_d = 1'b1;
                  key_ready_d   = 1'b1;
                  state_d       = S_IDLE;
               end
            end else if (data_start) begin
               if (state_q == S_NOKEY) begin
                  state_d = S_ERROR;
               end else begin
                  inverse_d      = decrypt;
                  r_d            = '0;
                  data_capture_d = 1'b1;
                  state_d        = S_KEYEXP;
               end
            end
         end
         S_KEYEXP: if (keyexp_finished) begin
            if (r_q == '0)     state_d = S_AROUND;
            else if (inverse_q) state_d = S_SROWS;
            else               state_d = S_SBYTES;
         end
         S_SBYTES: if (sbytes_finished) state_d = inverse_q ? S_AROUND : S_SROWS;
         S_SROWS: if (srows_finished) begin
            if (inverse_q)       state_d = S_SBYTES;
            else if (last_round) state_d = S_AROUND;
            else                 state_d = S_MCOL;
         end
         S_MCOL: if (mcol_finished) begin
            if (inverse_q) round_end = 1'b1;
            else           state_d   = S_AROUND;
         end
         S_AROUND: if (around_finished) begin
            if (!inverse_q || (r_q == '0) || last_round) round_end = 1'b1;
            else                                         state_d   = S_MCOL;
         end
         S_DONE: state_d = S_IDLE;
         S_ERROR: if (err_clear) begin
            state_d     = S_NOKEY;
            key_ready_d = 1'b0;
         end
         default: state_d = S_NOKEY;
      endcase

      if (round_end) begin
         if (last_round) begin
            state_d = S_DONE;
         end else begin
            r_d     = r_q + ROUND_W'(1);
            state_d = S_KEYEXP;
         end
      end

      // A work state that did not advance this cycle is still waiting on its unit
      if (work_state && (state_d == state_q)) begin
         if (wd_q == WD_W'(TIMEOUT - 1)) state_d = S_ERROR;
         else                            wd_d    = wd_q + WD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q        <= S_NOKEY;
         nr_q           <= ROUND_W'(10);
         r_q            <= '0;
         wd_q           <= '0;
         inverse_q      <= 1'b0;
         key_ready_q    <= 1'b0;
         key_capture_q  <= 1'b0;
         data_capture_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         nr_q           <= nr_d;
         r_q            <= r_d;
         wd_q           <= wd_d;
         inverse_q      <= inverse_d;
         key_ready_q    <= key_ready_d;
         key_capture_q  <= key_capture_d;
         data_capture_q <= data_capture_d;
      end
   end

   assign keyexp_enable = (state_q == S_KEYEXP);
   assign sbytes_enable = (state_q == S_SBYTES);
   assign srows_enable  = (state_q == S_SROWS);
   assign mcol_enable   = (state_q == S_MCOL);
   assign around_enable = (state_q == S_AROUND);
   assign busy          = work_state || (state_q == S_DONE);
   assign done          = (state_q == S_DONE);
   assign error         = (state_q == S_ERROR);
   assign key_capture   = key_capture_q;
   assign data_capture  = data_capture_q;
   assign inverse       = inverse_q;
   assign key_ready     = key_ready_q;
   assign roundnum      = r_q;
   assign key_index     = inverse_q ? (nr_q - r_q) : r_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: random unit latencies and mode/key choices checked
// against a round-order reference built from the cipher's per-round step lists.
module tb_aes_round_sequencer;

   localparam logic [4:0] KX = 5'b00001;
   localparam logic [4:0] SB = 5'b00010;
   localparam logic [4:0] SR = 5'b00100;
   localparam logic [4:0] MC = 5'b01000;
   localparam logic [4:0] AR = 5'b10000;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       key_load = 1'b0;
   logic [1:0] key_size = 2'b00;
   logic       data_start = 1'b0;
   logic       decrypt = 1'b0;
   logic       err_clear = 1'b0;
   logic [4:0] fin = 5'b0;

   logic       key_capture, data_capture, inverse, key_ready, busy, done, error;
   logic       keyexp_enable, sbytes_enable, srows_enable, mcol_enable, around_enable;
   logic [3:0] roundnum, key_index, dbg_state;
   logic [4:0] en;
   logic [19:0] outs;

   int checks = 0;
   int errors = 0;
   logic [12:0] exp_q[$];

   assign en   = {around_enable, mcol_enable, srows_enable, sbytes_enable, keyexp_enable};
   assign outs = {key_capture, data_capture, en, inverse, roundnum, key_index,
                  key_ready, busy, done, error};

   always #5 clk = ~clk;

   aes_round_sequencer #(.MAX_ROUNDS(14), .ROUND_W(4), .TIMEOUT(64)) dut (
      .clk(clk), .n_rst(n_rst), .key_load(key_load), .key_size(key_size),
      .data_start(data_start), .decrypt(decrypt), .err_clear(err_clear),
      .keyexp_finished(fin[0]), .sbytes_finished(fin[1]), .srows_finished(fin[2]),
      .mcol_finished(fin[3]), .around_finished(fin[4]),
      .key_capture(key_capture), .data_capture(data_capture),
      .keyexp_enable(keyexp_enable), .sbytes_enable(sbytes_enable),
      .srows_enable(srows_enable), .mcol_enable(mcol_enable), .around_enable(around_enable),
      .inverse(inverse), .roundnum(roundnum), .key_index(key_index),
      .key_ready(key_ready), .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
   );

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      n_rst = 1'b0;
      key_load = 1'b0; data_start = 1'b0; err_clear = 1'b0; fin = 5'b0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic load_key(input logic [1:0] sz);
      key_size = sz; key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_err_clear();
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
   endtask

   // Reference: the sequence of units, round number and round key each block visits
   task automatic build_exp(input int nr, input bit dec);
      logic [3:0] rr, kk;
      exp_q.delete();
      for (int r = 0; r <= nr; r++) begin
         rr = 4'(r);
         kk = dec ? 4'(nr - r) : 4'(r);
         exp_q.push_back({KX, rr, kk});
         if (r == 0) begin
            exp_q.push_back({AR, rr, kk});
         end else if (dec) begin
            exp_q.push_back({SR, rr, kk});
            exp_q.push_back({SB, rr, kk});
            exp_q.push_back({AR, rr, kk});
            if (r != nr) exp_q.push_back({MC, rr, kk});
         end else begin
            exp_q.push_back({SB, rr, kk});
            exp_q.push_back({SR, rr, kk});
            if (r != nr) exp_q.push_back({MC, rr, kk});
            exp_q.push_back({AR, rr, kk});
         end
      end
   endtask

   // Runs one block; each unit answers dly cycles after its enable rises, other
   // units strobe randomly. Stops early at SBYTES of hang_round when hang_round >= 0.
   task automatic run_block(input int nr, input bit dec, input int dly, input bit inject,
                            input int hang_round, output bit hung);
      int          cyc, wt, exp_lat;
      bit          new_step, got_done;
      logic [4:0]  act;
      logic [12:0] e;
      hung = 1'b0;
      build_exp(nr, dec);
      exp_lat = exp_q.size() * (dly + 1) + 1;
      decrypt = dec; data_start = 1'b1;
      @(negedge clk);
      data_start = 1'b0;
      checks++;
      if (data_capture !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_capture: data_capture=%b busy=%b, expected 1 1", data_capture, busy);
      end
      cyc = 1; new_step = 1'b1; wt = 0; got_done = 1'b0;
      while (cyc < 3000 && !got_done) begin
         fin = 5'b0; key_load = 1'b0; data_start = 1'b0;
         if (done === 1'b1) begin
            got_done = 1'b1;
            checks++;
            if (cyc != exp_lat || exp_q.size() != 0) begin
               errors++;
               $display("FAIL done_latency: done at cycle %0d with %0d steps left, expected cycle %0d, 0 left",
                        cyc, exp_q.size(), exp_lat);
            end
            checks++;
            if (roundnum !== 4'(nr) || key_index !== (dec ? 4'd0 : 4'(nr))) begin
               errors++;
               $display("FAIL final_round: roundnum=%0d key_index=%0d, expected %0d %0d",
                        roundnum, key_index, nr, dec ? 0 : nr);
            end
         end else begin
            act = en;
            if (new_step) begin
               if (hang_round >= 0 && act == SB && roundnum == 4'(hang_round)) begin
                  hung = 1'b1;
                  return;
               end
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL seq_extra: cycle %0d en=%b r=%0d beyond expected sequence", cyc, act, roundnum);
               end else begin
                  e = exp_q.pop_front();
                  if ({act, roundnum, key_index} !== e) begin
                     errors++;
                     $display("FAIL seq_step: cycle %0d en=%b r=%0d key_index=%0d, expected en=%b r=%0d key_index=%0d",
                              cyc, act, roundnum, key_index, e[12:8], e[7:4], e[3:0]);
                  end
               end
               checks++;
               if ({inverse, busy, key_capture, data_capture} !== {dec, 1'b1, 1'b0, (cyc == 1)}) begin
                  errors++;
                  $display("FAIL step_flags: cycle %0d inverse/busy/key_cap/data_cap=%b%b%b%b, expected %b1%b%b",
                           cyc, inverse, busy, key_capture, data_capture, dec, 1'b0, (cyc == 1));
               end
               new_step = 1'b0; wt = 0;
            end
            if (wt == dly) begin
               fin = act;
               new_step = 1'b1;
            end else begin
               wt++;
            end
            fin = fin | (5'($urandom) & ~act);
            if (inject && $urandom_range(0, 5) == 0) begin
               key_load = 1'b1; key_size = 2'($urandom); data_start = 1'b1; decrypt = ~dec;
            end
            @(negedge clk);
            cyc++;
         end
      end
      fin = 5'b0; key_load = 1'b0; data_start = 1'b0;
      checks++;
      if (!got_done) begin
         errors++;
         $display("FAIL block_timeout: no done within %0d cycles, expected done at %0d", cyc, exp_lat);
      end else begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0 || roundnum !== 4'(nr)) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b roundnum=%0d, expected 0 0 %0d", done, busy, roundnum, nr);
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      n_rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (outs !== 20'b0) begin
         errors++;
         $display("FAIL reset_held: outputs=%h state=%0d, expected 0", outs, dbg_state);
      end
      n_rst = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== 20'b0) begin
         errors++;
         $display("FAIL reset_released: outputs=%h state=%0d, expected 0", outs, dbg_state);
      end
   endtask

   task automatic test_key_load();
      key_size = 2'b00; key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      checks++;
      if ({key_capture, key_ready, busy, error} !== 4'b1100) begin
         errors++;
         $display("FAIL key_capture_pulse: cap/ready/busy/err=%b%b%b%b, expected 1100",
                  key_capture, key_ready, busy, error);
      end
      @(negedge clk);
      checks++;
      if (key_capture !== 1'b0 || key_ready !== 1'b1) begin
         errors++;
         $display("FAIL key_capture_end: key_capture=%b key_ready=%b, expected 0 1", key_capture, key_ready);
      end
   endtask

   task automatic test_encrypt_128();
      bit hung;
      load_key(2'b00);
      run_block(10, 1'b0, 0, 1'b0, -1, hung);
   endtask

   task automatic test_decrypt_256();
      bit hung;
      load_key(2'b10);
      run_block(14, 1'b1, 3, 1'b0, -1, hung);
   endtask

   task automatic test_random_blocks();
      bit hung;
      int sz;
      for (int i = 0; i < 5; i++) begin
         sz = $urandom_range(0, 2);
         load_key(2'(sz));
         run_block(10 + 2 * sz, 1'($urandom), $urandom_range(0, 2), 1'($urandom), -1, hung);
      end
   endtask

   task automatic test_invalid_key();
      do_reset();
      key_size = 2'b11; key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      checks++;
      if ({error, key_ready, key_capture, en} !== {3'b100, 5'b0}) begin
         errors++;
         $display("FAIL bad_key_nokey: err/ready/cap=%b%b%b en=%b, expected 100 00000",
                  error, key_ready, key_capture, en);
      end
      pulse_err_clear();
      checks++;
      if ({error, key_ready, busy} !== 3'b000) begin
         errors++;
         $display("FAIL err_clear_nokey: err/ready/busy=%b%b%b, expected 000", error, key_ready, busy);
      end
      data_start = 1'b1;
      @(negedge clk);
      data_start = 1'b0;
      checks++;
      if (error !== 1'b1 || data_capture !== 1'b0) begin
         errors++;
         $display("FAIL start_nokey: error=%b data_capture=%b, expected 1 0", error, data_capture);
      end
      pulse_err_clear();
      load_key(2'b01);
      key_size = 2'b11; key_load = 1'b1;
      @(negedge clk);
      key_load = 1'b0;
      checks++;
      if (error !== 1'b1 || key_ready !== 1'b1) begin
         errors++;
         $display("FAIL bad_key_idle: error=%b key_ready=%b, expected 1 1", error, key_ready);
      end
      key_size = 2'b00; key_load = 1'b1; data_start = 1'b1;
      @(negedge clk);
      key_load = 1'b0; data_start = 1'b0;
      checks++;
      if ({error, key_capture, data_capture, en} !== {3'b100, 5'b0}) begin
         errors++;
         $display("FAIL error_ignores: err/kcap/dcap=%b%b%b en=%b, expected 100 00000",
                  error, key_capture, data_capture, en);
      end
      pulse_err_clear();
      checks++;
      if (error !== 1'b0 || key_ready !== 1'b0) begin
         errors++;
         $display("FAIL err_clear_discard: error=%b key_ready=%b, expected 0 0", error, key_ready);
      end
   endtask

   task automatic test_watchdog();
      bit hung;
      for (int v = 0; v < 2; v++) begin
         do_reset();
         load_key(2'b00);
         run_block(10, 1'b0, 0, 1'b0, 3, hung);
         checks++;
         if (!hung) begin
            errors++;
            $display("FAIL wd_reach: SBYTES of round 3 never reached, expected it");
         end
         repeat (63) @(negedge clk);
         checks++;
         if (sbytes_enable !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL wd_hold: cycle 64 sbytes_enable=%b error=%b, expected 1 0", sbytes_enable, error);
         end
         if (v == 1) fin = SB;
         @(negedge clk);
         fin = 5'b0;
         checks++;
         if (v == 0) begin
            if (error !== 1'b1 || en !== 5'b0) begin
               errors++;
               $display("FAIL wd_expire: error=%b en=%b, expected 1 00000", error, en);
            end
         end else if (error !== 1'b0 || en !== SR || roundnum !== 4'd3) begin
            errors++;
            $display("FAIL wd_last_cycle: error=%b en=%b r=%0d, expected 0 %b 3", error, en, roundnum, SR);
         end
      end
      do_reset();
   endtask

   task automatic test_simultaneous();
      bit hung;
      load_key(2'b00);
      key_size = 2'b01; key_load = 1'b1; data_start = 1'b1; decrypt = 1'b0;
      @(negedge clk);
      key_load = 1'b0; data_start = 1'b0;
      checks++;
      if ({key_capture, data_capture} !== 2'b10) begin
         errors++;
         $display("FAIL both_capture: key_cap=%b data_cap=%b, expected 1 0", key_capture, data_capture);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || en !== 5'b0) begin
         errors++;
         $display("FAIL both_no_start: busy=%b en=%b, expected 0 00000", busy, en);
      end
      run_block(12, 1'b0, 0, 1'b1, -1, hung);
   endtask

   task automatic test_reset_mid();
      bit hung;
      load_key(2'b10);
      run_block(14, 1'b0, 0, 1'b0, 5, hung);
      checks++;
      if (!hung) begin
         errors++;
         $display("FAIL mid_reach: round 5 never reached, expected it");
      end
      #2 n_rst = 1'b0;
      #1;
      checks++;
      if (outs !== 20'b0) begin
         errors++;
         $display("FAIL reset_async: outputs=%h, expected 0", outs);
      end
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({key_ready, busy, done, error} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_after: ready/busy/done/err=%b%b%b%b, expected 0000",
                  key_ready, busy, done, error);
      end
      data_start = 1'b1;
      @(negedge clk);
      data_start = 1'b0;
      checks++;
      if (error !== 1'b1) begin
         errors++;
         $display("FAIL reset_nokey: error=%b, expected 1", error);
      end
      pulse_err_clear();
   endtask

   initial begin
      test_reset();
      test_key_load();
      test_encrypt_128();
      test_decrypt_256();
      test_invalid_key();
      test_watchdog();
      test_simultaneous();
      test_random_blocks();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
